// File: rtl/stepper_axil_slave.sv
// stepper_axil_slave
// AXI4-Lite register block that gates the NEORV32 clock enable. Software can
// hold the core, let it free-run, or advance it by an exact number of cycles.
//
// Ports:
//   ACLK, ARESETN         clock, synchronous active-low reset
//   S_AXI_AW*/W*/B*       AXI4-Lite write channels (AW and W accepted together)
//   S_AXI_AR*/R*          AXI4-Lite read channels
//   proc_clk_en           registered clock enable for the core
//   proc_step_done        one-cycle pulse when a step burst runs out
//
// Register map (index = addr[3:2]):
//   0 CTRL      RW  bit0 FREE, bit1 START (W1, reads 0), bit2 CLR_OVR (W1, reads 0)
//   1 STEP_LEN  RW  low COUNT_WIDTH bits give the burst length
//   2 STATUS    RO  bit0 BUSY, bit1 FREE_RUN, bit2 OVR (sticky)
//   3 REMAINING RO  cycles left in the current burst
module stepper_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int COUNT_WIDTH        = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            proc_clk_en,
  output logic                            proc_step_done
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  typedef enum logic [1:0] {IDLE, STEP, FREE} state_t;

  state_t                 state;
  logic [DW-1:0]          ctrl_q, len_q;
  logic                   ovr_q;
  logic [COUNT_WIDTH-1:0] cnt;

  logic [1:0]    wr_idx, rd_idx;
  logic          wr_go, wr_fire, rd_go, rd_fire;
  logic [DW-1:0] ctrl_mrg, len_mrg, rem_ext, rd_mux;
  logic          ctrl_wr, free_nxt, start, clr_ovr, ovr_evt;
  logic          unused;

  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;

  assign wr_idx  = S_AXI_AWADDR[3:2];
  assign rd_idx  = S_AXI_ARADDR[3:2];
  assign wr_go   = S_AXI_AWVALID & S_AXI_WVALID & ~S_AXI_BVALID & ~S_AXI_AWREADY;
  assign wr_fire = S_AXI_AWREADY & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_go   = S_AXI_ARVALID & ~S_AXI_RVALID & ~S_AXI_ARREADY;
  assign rd_fire = S_AXI_ARREADY & S_AXI_ARVALID;

  // Byte-strobed merge of the write data into the RW registers.
  always_comb begin
    ctrl_mrg = ctrl_q;
    len_mrg  = len_q;
    for (int b = 0; b < SW; b++) begin
      if (S_AXI_WSTRB[b]) begin
        ctrl_mrg[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
        len_mrg[8*b +: 8]  = S_AXI_WDATA[8*b +: 8];
      end
    end
    // START/CLR_OVR are pulses, never stored
    ctrl_mrg[2:1] = 2'b00;
  end

  // Control decode looks at the write being accepted this edge so that a
  // START or FREE change takes effect on the accept edge itself.
  assign ctrl_wr  = wr_fire && (wr_idx == 2'd0);
  assign free_nxt = (ctrl_wr && S_AXI_WSTRB[0]) ? S_AXI_WDATA[0] : ctrl_q[0];
  assign start    = ctrl_wr && S_AXI_WSTRB[0] && S_AXI_WDATA[1];
  assign clr_ovr  = ctrl_wr && S_AXI_WSTRB[0] && S_AXI_WDATA[2];
  assign ovr_evt  = start && (state != IDLE);

  always_comb begin
    rem_ext = '0;
    rem_ext[COUNT_WIDTH-1:0] = cnt;
  end

  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      2'd0: rd_mux = ctrl_q;
      2'd1: rd_mux = len_q;
      2'd2: rd_mux[2:0] = {ovr_q, state == FREE, state == STEP};
      default: rd_mux = rem_ext;
    endcase
  end

  // AXI-Lite handshakes and RW registers
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      ctrl_q        <= '0;
      len_q         <= '0;
    end else begin
      S_AXI_AWREADY <= wr_go;
      S_AXI_WREADY  <= wr_go;
      if (wr_fire)           S_AXI_BVALID <= 1'b1;
      else if (S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
      if (wr_fire) begin
        if (wr_idx == 2'd0) ctrl_q <= ctrl_mrg;
        if (wr_idx == 2'd1) len_q  <= len_mrg;
      end

      S_AXI_ARREADY <= rd_go;
      if (rd_fire) begin
        S_AXI_RDATA  <= rd_mux;
        S_AXI_RVALID <= 1'b1;
      end else if (S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  // Stepper FSM; proc_clk_en is a flop so the core sees a clean enable
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state          <= IDLE;
      cnt            <= '0;
      ovr_q          <= 1'b0;
      proc_clk_en    <= 1'b0;
      proc_step_done <= 1'b0;
    end else begin
      proc_step_done <= 1'b0;
      // a fresh overrun wins over a clear in the same write
      if (ovr_evt)      ovr_q <= 1'b1;
      else if (clr_ovr) ovr_q <= 1'b0;

      case (state)
        IDLE: begin
          if (free_nxt) begin
            state       <= FREE;
            proc_clk_en <= 1'b1;
          end else if (start && (|len_q[COUNT_WIDTH-1:0])) begin
            state       <= STEP;
            cnt         <= len_q[COUNT_WIDTH-1:0];
            proc_clk_en <= 1'b1;
          end else begin
            proc_clk_en <= 1'b0;
          end
        end
        STEP: begin
          if (free_nxt) begin
            state       <= FREE;
            cnt         <= '0;
            proc_clk_en <= 1'b1;
          end else if (cnt == COUNT_WIDTH'(1)) begin
            state          <= IDLE;
            cnt            <= '0;
            proc_clk_en    <= 1'b0;
            proc_step_done <= 1'b1;
          end else begin
            cnt         <= cnt - 1'b1;
            proc_clk_en <= 1'b1;
          end
        end
        FREE: begin
          if (!free_nxt) begin
            state       <= IDLE;
            proc_clk_en <= 1'b0;
          end else begin
            proc_clk_en <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          proc_clk_en <= 1'b0;
        end
      endcase
    end
  end
endmodule
